// File: rtl/mole_hit_scorer.sv
// Whack-a-mole scorer: debounces 9 buttons, judges presses against the lit moles,
// pulses hit_clear back to the LED driver and shows a saturating BCD score on HEX1:HEX0.
// Optional build macro MOLE_MISS_PENALTY_EN: a press on an unlit mole subtracts one point.
module mole_hit_scorer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCORE_MAX       = 99
) (
  input  logic       cin,
  input  logic       KEY0,
  input  logic [8:0] SW,
  input  logic [8:0] mole_led,
  input  logic       start,
  input  logic       round_end,
  output logic [8:0] hit_clear,
  output logic       playing,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [8:0]  r_sync1, r_sync2, r_db, r_db_d;
  logic [CW-1:0] r_cnt [9];
  logic [8:0]  r_hit_pend;
  logic [3:0]  r_ones, r_tens;
  logic [3:0]  w_ones_nxt, w_tens_nxt;
  logic [8:0]  w_rise, w_new, w_busy, w_hit_sel;
  logic [6:0]  w_val;
  logic        w_play_live, w_enter, w_inc;
`ifdef MOLE_MISS_PENALTY_EN
  logic [8:0]  r_miss_pend, w_miss_sel;
  logic        w_dec;
`endif

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'hC0;  4'd1: seg7 = 8'hF9;  4'd2: seg7 = 8'hA4;
      4'd3: seg7 = 8'hB0;  4'd4: seg7 = 8'h99;  4'd5: seg7 = 8'h92;
      4'd6: seg7 = 8'h82;  4'd7: seg7 = 8'hF8;  4'd8: seg7 = 8'h80;
      4'd9: seg7 = 8'h90;  default: seg7 = 8'hFF;
    endcase
  endfunction

  // NOTE: every clocked block uses <= so all flops sample pre-edge values, whatever order they are written in.
  always_ff @(posedge cin or negedge KEY0) begin
    if (!KEY0) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= SW;
      r_sync2 <= r_sync1;
    end
  end

  // NOTE: the counter array is plain flops, not a RAM, so it takes the async reset like any other register.
  always_ff @(posedge cin or negedge KEY0) begin
    if (!KEY0) begin
      r_db   <= '0;
      r_db_d <= '0;
      for (int n = 0; n < 9; n++) r_cnt[n] <= '0;
    end else begin
      r_db_d <= r_db;
      for (int n = 0; n < 9; n++) begin
        if (r_sync2[n] != r_db[n]) begin
          if (r_cnt[n] == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_db[n]  <= r_sync2[n];
            r_cnt[n] <= '0;
          end else begin
            r_cnt[n] <= r_cnt[n] + CW'(1);
          end
        end else begin
          r_cnt[n] <= '0;
        end
      end
    end
  end

  always_ff @(posedge cin or negedge KEY0) begin
    if (!KEY0) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: defaults first, so every path assigns every output and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start && !round_end) w_state_nxt = S_PLAY;
      S_PLAY:         if (round_end)           w_state_nxt = S_DONE;
      default:                                 w_state_nxt = S_IDLE;
    endcase
  end

  // round_end in the same cycle as a pending bit flushes it rather than scoring it.
  assign w_play_live = (r_state == S_PLAY) && !round_end;
  assign w_enter     = (r_state != S_PLAY) && (w_state_nxt == S_PLAY);
  assign playing     = (r_state == S_PLAY);

  assign w_rise    = r_db & ~r_db_d;
  assign w_new     = w_play_live ? (w_rise & ~w_busy) : 9'd0;
  assign w_hit_sel = r_hit_pend & (~r_hit_pend + 9'd1);
  assign hit_clear = w_play_live ? w_hit_sel : 9'd0;

  assign w_val = ({3'd0, r_tens} * 7'd10) + {3'd0, r_ones};
  assign w_inc = w_play_live && (|r_hit_pend) && (w_val < 7'(SCORE_MAX));

`ifdef MOLE_MISS_PENALTY_EN
  assign w_busy     = r_hit_pend | r_miss_pend;
  assign w_miss_sel = (|r_hit_pend) ? 9'd0 : (r_miss_pend & (~r_miss_pend + 9'd1));
  assign w_dec      = w_play_live && (|w_miss_sel) && (w_val != 7'd0);

  always_ff @(posedge cin or negedge KEY0) begin
    if (!KEY0)             r_miss_pend <= '0;
    else if (!w_play_live) r_miss_pend <= '0;
    else                   r_miss_pend <= (r_miss_pend | (w_new & ~mole_led)) & ~w_miss_sel;
  end
`else
  assign w_busy = r_hit_pend;
`endif

  always_ff @(posedge cin or negedge KEY0) begin
    if (!KEY0)             r_hit_pend <= '0;
    else if (!w_play_live) r_hit_pend <= '0;
    else                   r_hit_pend <= (r_hit_pend | (w_new & mole_led)) & ~w_hit_sel;
  end

  always_comb begin
    w_ones_nxt = r_ones;
    w_tens_nxt = r_tens;
    if (w_enter) begin
      w_ones_nxt = 4'd0;
      w_tens_nxt = 4'd0;
    end else if (w_inc) begin
      if (r_ones == 4'd9) begin
        w_ones_nxt = 4'd0;
        w_tens_nxt = r_tens + 4'd1;
      end else begin
        w_ones_nxt = r_ones + 4'd1;
      end
`ifdef MOLE_MISS_PENALTY_EN
    end else if (w_dec) begin
      if (r_ones == 4'd0) begin
        w_ones_nxt = 4'd9;
        w_tens_nxt = r_tens - 4'd1;
      end else begin
        w_ones_nxt = r_ones - 4'd1;
      end
`endif
    end
  end

  // HEX registers load the next score so the display changes on the same edge as the score.
  always_ff @(posedge cin or negedge KEY0) begin
    if (!KEY0) begin
      r_ones <= 4'd0;
      r_tens <= 4'd0;
      HEX0   <= 8'hC0;
      HEX1   <= 8'hC0;
    end else begin
      r_ones <= w_ones_nxt;
      r_tens <= w_tens_nxt;
      HEX0   <= seg7(w_ones_nxt);
      HEX1   <= seg7(w_tens_nxt);
    end
  end

endmodule
